// File: rtl/fifo_async_sc_if.sv
// Handshake bundle between the producer/consumer side and the FIFO.
// The master drives the requests and write data. The slave (the FIFO)
// drives read data and the two status flags.
interface fifo_async_sc_if #(
  parameter int DATA_WIDTH = 2
);
  logic                  i_wr;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic                  i_rd;
  logic [DATA_WIDTH-1:0] o_rdata;
  logic                  o_full;
  logic                  o_empty;

  modport master (
    output i_wr, i_wdata, i_rd,
    input  o_rdata, o_full, o_empty
  );

  modport slave (
    input  i_wr, i_wdata, i_rd,
    output o_rdata, o_full, o_empty
  );
endinterface

// File: rtl/fifo_async_sc.sv
// Single-clock FIFO built on the dual-clock architecture.
// Storage is 2**ADDR_WIDTH words. Binary and Gray pointers carry one extra wrap bit.
// Each pointer crosses to the opposite side through a two-flop synchronizer, even
// though both sides share one clock. The flags are therefore pessimistic in the same
// way, and on the same cycles, as in the true dual-clock part.
module fifo_async_sc #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  fifo_async_sc_if.slave    bus
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [PW-1:0]         wbin, wgray, rbin, rgray;
  logic [PW-1:0]         wbin_next, wgray_next, rbin_next, rgray_next;
  logic [PW-1:0]         wq_p1, wq_p2, rq_p1, rq_p2;
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic                  wr_ok, rd_ok;
  logic                  full, empty, full_next, empty_next;
  logic [DATA_WIDTH-1:0] rdata;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // A request is only honoured when its own flag allows it.
  assign wr_ok = bus.i_wr & ~full;
  assign rd_ok = bus.i_rd & ~empty;

  assign waddr = wbin[ADDR_WIDTH-1:0];
  assign raddr = rbin[ADDR_WIDTH-1:0];

  assign wbin_next  = wbin + {{(PW-1){1'b0}}, wr_ok};
  assign rbin_next  = rbin + {{(PW-1){1'b0}}, rd_ok};
  assign wgray_next = bin2gray(wbin_next);
  assign rgray_next = bin2gray(rbin_next);

  // Full: the writer is exactly one lap ahead of the synchronized read pointer.
  // In Gray code that means the two MSBs are inverted and the other bits are equal.
  assign full_next  = (wgray_next == {~rq_p2[PW-1:PW-2], rq_p2[PW-3:0]});
  assign empty_next = (rgray_next == wq_p2);

  // Storage array. It has no reset, so stale words simply get overwritten.
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[waddr] <= bus.i_wdata;
  end

  // Registered read port. It updates only on an accepted read and holds otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      rdata <= '0;
    else if (rd_ok) rdata <= mem[raddr];
  end

  // Write-side pointers and the full flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wbin  <= '0;
      wgray <= '0;
      full  <= 1'b0;
    end else begin
      wbin  <= wbin_next;
      wgray <= wgray_next;
      full  <= full_next;
    end
  end

  // Read-side pointers and the empty flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rbin  <= '0;
      rgray <= '0;
      empty <= 1'b1;
    end else begin
      rbin  <= rbin_next;
      rgray <= rgray_next;
      empty <= empty_next;
    end
  end

  // Two-stage pointer synchronizers: write Gray toward the reader, read Gray toward the writer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wq_p1 <= '0;
      wq_p2 <= '0;
      rq_p1 <= '0;
      rq_p2 <= '0;
    end else begin
      wq_p1 <= wgray;
      wq_p2 <= wq_p1;
      rq_p1 <= rgray;
      rq_p2 <= rq_p1;
    end
  end

  assign bus.o_rdata = rdata;
  assign bus.o_full  = full;
  assign bus.o_empty = empty;

endmodule

// File: tb/tb_fifo_async_sc.sv
// Bench for fifo_async_sc.
// The reference model is a data queue plus running write/read totals. Each flag is
// computed from the totals the opposite side saw three edges earlier.
module tb_fifo_async_sc;
  localparam int DW    = 2;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;

  fifo_async_sc_if #(.DATA_WIDTH(DW)) bus();

  fifo_async_sc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [DW-1:0] mq[$];
  int            wtot, rtot;
  int            wp[3];          // write totals after the previous 1, 2 and 3 edges
  int            rp[3];          // read totals after the previous 1, 2 and 3 edges
  bit            m_full, m_empty;
  logic [DW-1:0] m_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    wtot = 0;
    rtot = 0;
    for (int i = 0; i < 3; i++) begin
      wp[i] = 0;
      rp[i] = 0;
    end
    m_full  = 1'b0;
    m_empty = 1'b1;
    m_rdata = '0;
  endtask

  task automatic model_step();
    bit wa, ra;
    wa = bus.i_wr && !m_full;
    ra = bus.i_rd && !m_empty;
    if (ra) begin
      m_rdata = mq.pop_front();
      rtot++;
    end
    if (wa) begin
      mq.push_back(bus.i_wdata);
      wtot++;
    end
    // The reader sees the write total from three edges ago; the writer sees the read total likewise.
    m_empty = (rtot == wp[2]);
    m_full  = ((wtot - rp[2]) == DEPTH);
    wp[2] = wp[1]; wp[1] = wp[0]; wp[0] = wtot;
    rp[2] = rp[1]; rp[1] = rp[0]; rp[0] = rtot;
  endtask

  // Model advances on every clock edge and resets asynchronously.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("model_rdata", 32'(bus.o_rdata), 32'(m_rdata));
      check("model_full",  32'(bus.o_full),  32'(m_full));
      check("model_empty", 32'(bus.o_empty), 32'(m_empty));
    end
  end

  task automatic drive(input logic wr, input logic [DW-1:0] wd, input logic rd);
    bus.i_wr    = wr;
    bus.i_wdata = wd;
    bus.i_rd    = rd;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 1'b0);
    repeat (3) tick();
    check("rst_empty", 32'(bus.o_empty), 32'd1);
    check("rst_full",  32'(bus.o_full),  32'd0);
    check("rst_rdata", 32'(bus.o_rdata), 32'd0);
    rst = 1'b0;

    // 1: reads on an empty FIFO change nothing
    drive(1'b0, 2'd0, 1'b1);
    repeat (4) tick();
    check("t1_empty", 32'(bus.o_empty), 32'd1);
    check("t1_rdata", 32'(bus.o_rdata), 32'd0);

    // 2: single write, empty falls on the third edge after it
    drive(1'b1, 2'b11, 1'b0);
    tick();
    drive(1'b0, 2'd0, 1'b0);
    check("t2_empty_e0", 32'(bus.o_empty), 32'd1);
    tick();
    check("t2_empty_e1", 32'(bus.o_empty), 32'd1);
    tick();
    check("t2_empty_e2", 32'(bus.o_empty), 32'd1);
    tick();
    check("t2_empty_e3", 32'(bus.o_empty), 32'd0);
    drive(1'b0, 2'd0, 1'b1);
    tick();
    drive(1'b0, 2'd0, 1'b0);
    check("t2_rdata", 32'(bus.o_rdata), 32'd3);
    check("t2_empty_after_rd", 32'(bus.o_empty), 32'd1);
    tick();

    // 3: 20 writes with no reads; full on the 16th, the rest dropped
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 2'(i % 4), 1'b0);
      tick();
      if (i == 14) check("t3_full_15", 32'(bus.o_full), 32'd0);
      if (i == 15) check("t3_full_16", 32'(bus.o_full), 32'd1);
      if (i == 19) check("t3_full_20", 32'(bus.o_full), 32'd1);
    end
    drive(1'b0, 2'd0, 1'b0);
    repeat (2) tick();

    // 4: one read from full, full lingers 3 edges, then drain in order
    drive(1'b0, 2'd0, 1'b1);
    tick();
    drive(1'b0, 2'd0, 1'b0);
    check("t4_rdata_0", 32'(bus.o_rdata), 32'd0);
    check("t4_full_r0", 32'(bus.o_full), 32'd1);
    tick();
    check("t4_full_r1", 32'(bus.o_full), 32'd1);
    tick();
    check("t4_full_r2", 32'(bus.o_full), 32'd1);
    tick();
    check("t4_full_r3", 32'(bus.o_full), 32'd0);
    for (int i = 1; i < 16; i++) begin
      drive(1'b0, 2'd0, 1'b1);
      tick();
      check("t4_rdata_seq", 32'(bus.o_rdata), 32'(i % 4));
    end
    drive(1'b0, 2'd0, 1'b0);
    check("t4_empty_end", 32'(bus.o_empty), 32'd1);
    tick();

    // 5: half full, then simultaneous read/write across the pointer wrap
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), 1'b0);
      tick();
    end
    drive(1'b0, 2'd0, 1'b0);
    repeat (4) tick();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), 1'b1);
      tick();
      check("t5_full_steady",  32'(bus.o_full),  32'd0);
      check("t5_empty_steady", 32'(bus.o_empty), 32'd0);
    end
    drive(1'b0, 2'd0, 1'b1);
    repeat (12) tick();
    check("t5_empty_drained", 32'(bus.o_empty), 32'd1);
    drive(1'b0, 2'd0, 1'b0);

    // 6: asynchronous reset with 5 words held, then fresh data
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd1, 1'b0);
      tick();
    end
    drive(1'b0, 2'd0, 1'b0);
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_empty", 32'(bus.o_empty), 32'd1);
    check("t6_rst_full",  32'(bus.o_full),  32'd0);
    check("t6_rst_rdata", 32'(bus.o_rdata), 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b1, 2'b10, 1'b0);
    tick();
    drive(1'b0, 2'd0, 1'b0);
    repeat (3) tick();
    check("t6_empty_new", 32'(bus.o_empty), 32'd0);
    drive(1'b0, 2'd0, 1'b1);
    tick();
    drive(1'b0, 2'd0, 1'b0);
    check("t6_rdata_new", 32'(bus.o_rdata), 32'd2);
    check("t6_empty_after", 32'(bus.o_empty), 32'd1);

    // Random traffic with shifting write/read bias and one mid-run reset
    for (int c = 0; c < 800; c++) begin
      int pw;
      int pr;
      pw = ((c / 100) % 2 == 0) ? 75 : 30;
      pr = ((c / 100) % 2 == 0) ? 30 : 75;
      drive(1'($urandom_range(0, 99) < pw), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 99) < pr));
      if (c == 450) begin
        #3;
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    drive(1'b0, 2'd0, 1'b0);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
